// File: rtl/capture_sequencer_if.sv
// capture_sequencer_if: bundles every non-clock signal of the capture sequencer.
//
// Modports:
//   master - the sequencer side. It accepts commands, drives the buffer
//            control, readout start and software-reset requests, and reports status.
//   slave  - the environment side. This is the host, the trigger manager,
//            the capture buffer and the readout engine.
//
// Signals:
//   cmd_valid/cmd_ready/cmd_data         command in; cmd_data MSB = abort, low bits = N
//   trigger_seen                         trigger manager has fired (level)
//   capture_ctl_valid/ready/data         {arm, start, stop} to the capture buffer
//   write_depth_valid                    buffer reports write depth after stop
//   readout_start_valid/ready            readout start request
//   sw_reset_valid/ready                 capture + readout software reset
//   readout_last_ok                      final readout beat accepted
//   busy/done/timeout_err/state          status
interface capture_sequencer_if #(
    parameter int unsigned POST_TRIG_BITS = 16
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [POST_TRIG_BITS:0]   cmd_data;
    logic                      trigger_seen;
    logic                      capture_ctl_valid;
    logic                      capture_ctl_ready;
    logic [2:0]                capture_ctl_data;
    logic                      write_depth_valid;
    logic                      readout_start_valid;
    logic                      readout_start_ready;
    logic                      sw_reset_valid;
    logic                      sw_reset_ready;
    logic                      readout_last_ok;
    logic                      busy;
    logic                      done;
    logic                      timeout_err;
    logic [3:0]                state;

    modport master (
        input  cmd_valid, cmd_data, trigger_seen, capture_ctl_ready, write_depth_valid,
               readout_start_ready, sw_reset_ready, readout_last_ok,
        output cmd_ready, capture_ctl_valid, capture_ctl_data, readout_start_valid,
               sw_reset_valid, busy, done, timeout_err, state
    );

    modport slave (
        output cmd_valid, cmd_data, trigger_seen, capture_ctl_ready, write_depth_valid,
               readout_start_ready, sw_reset_ready, readout_last_ok,
        input  cmd_ready, capture_ctl_valid, capture_ctl_data, readout_start_valid,
               sw_reset_valid, busy, done, timeout_err, state
    );
endinterface

// File: rtl/capture_sequencer.sv
// capture_sequencer: runs one capture from arm to readout.
//
// The sequence is: arm the buffer, wait for the trigger, hold for N
// post-trigger cycles, stop the buffer, wait for its write depth, start the
// readout and wait for the final beat. An abort command accepted in any busy
// state drops the current step and issues a software reset instead.
//
// Ports:
//   ps_clk      sole clock
//   ps_reset_n  asynchronous active-low reset
//   bus         capture_sequencer_if.master (command, buffer control, readout,
//               software reset, status)
//
// Parameters:
//   POST_TRIG_BITS  width of the post-trigger hold count N
//   TIMEOUT_CYCLES  trigger-wait limit; used only with the timeout build
//
// Build option:
//   CAPTURE_SEQUENCER_TIMEOUT_EN - when defined, WAIT_TRIG gives up after
//   TIMEOUT_CYCLES cycles without a trigger. It then sets the sticky timeout_err
//   and aborts. When undefined, there is no timeout counter and timeout_err is
//   tied low.
module capture_sequencer #(
    parameter int unsigned POST_TRIG_BITS = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                ps_clk,
    input  logic                ps_reset_n,
    capture_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        StIdle      = 4'd0,
        StArm       = 4'd1,
        StWaitTrig  = 4'd2,
        StPost      = 4'd3,
        StStop      = 4'd4,
        StWaitDepth = 4'd5,
        StStartRo   = 4'd6,
        StReadout   = 4'd7,
        StAbort     = 4'd8
    } state_e;

    localparam logic [2:0] CtlArm  = 3'b100;
    localparam logic [2:0] CtlStop = 3'b001;

    // Elaboration-time sanity check; both parameters must be non-zero.
    if (POST_TRIG_BITS == 0 || TIMEOUT_CYCLES == 0) begin : gen_param_check
        $error("capture_sequencer: POST_TRIG_BITS and TIMEOUT_CYCLES must be non-zero");
    end

    state_e                    state_q;
    logic [POST_TRIG_BITS-1:0] n_q;
    logic [POST_TRIG_BITS-1:0] cnt_q;
    logic                      capture_ctl_valid_q;
    logic [2:0]                capture_ctl_data_q;
    logic                      readout_start_valid_q;
    logic                      sw_reset_valid_q;
    logic                      done_q;

    logic is_abort;
    logic cmd_fire;
    logic abort_fire;
    logic start_fire;
    logic tmo_hit;

    // Abort commands are accepted every cycle. Start commands are accepted
    // only in IDLE.
    assign is_abort   = bus.cmd_data[POST_TRIG_BITS];
    assign bus.cmd_ready = (state_q == StIdle) || is_abort;
    assign cmd_fire   = bus.cmd_valid && bus.cmd_ready;
    assign abort_fire = cmd_fire && is_abort && (state_q != StIdle);
    assign start_fire = cmd_fire && !is_abort && (state_q == StIdle);

`ifdef CAPTURE_SEQUENCER_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TmoW-1:0] tmo_q;
    logic            timeout_err_q;

    // tmo_q counts completed WAIT_TRIG cycles. The limit is reached in the
    // TIMEOUT_CYCLES-th cycle.
    assign tmo_hit = (state_q == StWaitTrig) && !bus.trigger_seen && !abort_fire &&
                     (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ps_clk or negedge ps_reset_n) begin
        if (!ps_reset_n) begin
            tmo_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (state_q == StWaitTrig) begin
                tmo_q <= tmo_q + TmoW'(1);
            end else begin
                tmo_q <= '0;
            end
            if (tmo_hit) begin
                timeout_err_q <= 1'b1;
            end else if (start_fire) begin
                timeout_err_q <= 1'b0;
            end
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    assign tmo_hit         = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge ps_clk or negedge ps_reset_n) begin
        if (!ps_reset_n) begin
            state_q               <= StIdle;
            n_q                   <= '0;
            cnt_q                 <= '0;
            capture_ctl_valid_q   <= 1'b0;
            capture_ctl_data_q    <= 3'b000;
            readout_start_valid_q <= 1'b0;
            sw_reset_valid_q      <= 1'b0;
            done_q                <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_fire) begin
                // Any same-cycle handshake has already completed on the bus.
                // Only the request is withdrawn here.
                state_q               <= StAbort;
                capture_ctl_valid_q   <= 1'b0;
                capture_ctl_data_q    <= 3'b000;
                readout_start_valid_q <= 1'b0;
                sw_reset_valid_q      <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_fire) begin
                            n_q                 <= bus.cmd_data[POST_TRIG_BITS-1:0];
                            state_q             <= StArm;
                            capture_ctl_valid_q <= 1'b1;
                            capture_ctl_data_q  <= CtlArm;
                        end
                    end
                    StArm: begin
                        if (bus.capture_ctl_ready) begin
                            capture_ctl_valid_q <= 1'b0;
                            capture_ctl_data_q  <= 3'b000;
                            state_q             <= StWaitTrig;
                        end
                    end
                    StWaitTrig: begin
                        if (bus.trigger_seen) begin
                            cnt_q   <= n_q;
                            state_q <= StPost;
                        end else if (tmo_hit) begin
                            state_q          <= StAbort;
                            sw_reset_valid_q <= 1'b1;
                        end
                    end
                    StPost: begin
                        // The count reaches zero in this cycle when it is 1.
                        // N=0 also leaves after one POST cycle.
                        if (cnt_q <= POST_TRIG_BITS'(1)) begin
                            cnt_q               <= '0;
                            state_q             <= StStop;
                            capture_ctl_valid_q <= 1'b1;
                            capture_ctl_data_q  <= CtlStop;
                        end else begin
                            cnt_q <= cnt_q - POST_TRIG_BITS'(1);
                        end
                    end
                    StStop: begin
                        if (bus.capture_ctl_ready) begin
                            capture_ctl_valid_q <= 1'b0;
                            capture_ctl_data_q  <= 3'b000;
                            state_q             <= StWaitDepth;
                        end
                    end
                    StWaitDepth: begin
                        if (bus.write_depth_valid) begin
                            readout_start_valid_q <= 1'b1;
                            state_q               <= StStartRo;
                        end
                    end
                    StStartRo: begin
                        if (bus.readout_start_ready) begin
                            readout_start_valid_q <= 1'b0;
                            state_q               <= StReadout;
                        end
                    end
                    StReadout: begin
                        if (bus.readout_last_ok) begin
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                    StAbort: begin
                        if (bus.sw_reset_ready) begin
                            sw_reset_valid_q <= 1'b0;
                            state_q          <= StIdle;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign bus.capture_ctl_valid   = capture_ctl_valid_q;
    assign bus.capture_ctl_data    = capture_ctl_data_q;
    assign bus.readout_start_valid = readout_start_valid_q;
    assign bus.sw_reset_valid      = sw_reset_valid_q;
    assign bus.done                = done_q;
    assign bus.busy                = (state_q != StIdle);
    assign bus.state               = state_q;

endmodule
